// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker
// Result/statistics stage behind the 3-bit magnitude comparator. It consumes
// the one-hot gr/le/eq flags one sample per valid cycle. For each outcome it
// keeps a saturating event count. A lock FSM follows runs of "equal" and
// "non-equal" results. A sticky error flag records any malformed flag
// combination.
//
// rst and clr are both synchronous and have identical effect. clr acts as the
// soft reset of this block, and it overrides a sample presented in the same
// cycle.

module cmp_result_tracker #(
    parameter int CNT_W    = 8,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             gr,
    input  logic             le,
    input  logic             eq,
    input  logic             clr,
    output logic [CNT_W-1:0] gr_cnt,
    output logic [CNT_W-1:0] le_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic             locked,
    output logic             err,
    output logic [1:0]       state
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOSING  = 2'd3
    } state_t;

    // Run thresholds narrowed to the 4-bit run counter (both are 1..15).
    localparam logic [3:0] LOCK_RUN   = LOCK_N[3:0];
    localparam logic [3:0] UNLOCK_RUN = UNLOCK_N[3:0];
    localparam logic       LOCK_ONE   = (LOCK_N == 1);
    localparam logic       UNLOCK_ONE = (UNLOCK_N == 1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // The flags form a legal sample only when exactly one of them is set.
    function automatic logic flags_onehot(input logic [2:0] flags);
        logic ok;
        case (flags)
            3'b001:  ok = 1'b1;
            3'b010:  ok = 1'b1;
            3'b100:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Saturating increment: the counter holds at all-ones and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (&cnt) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       run_r;
    logic [3:0]       run_nxt_s;
    logic [3:0]       run_inc_s;
    logic             locked_r;
    logic             err_r;
    logic [CNT_W-1:0] gr_cnt_r;
    logic [CNT_W-1:0] le_cnt_r;
    logic [CNT_W-1:0] eq_cnt_r;

    logic             clear_s;
    logic             legal_s;
    logic             illegal_s;
    logic             is_eq_s;
    logic             is_neq_s;

    // Qualify the incoming sample. Clear takes priority over any sample.
    always_comb begin
        clear_s   = rst | clr;
        legal_s   = 1'b0;
        illegal_s = 1'b0;
        if (in_valid && !clear_s) begin
            legal_s   = flags_onehot({gr, le, eq});
            illegal_s = ~flags_onehot({gr, le, eq});
        end else begin
            legal_s   = 1'b0;
            illegal_s = 1'b0;
        end
        is_eq_s  = legal_s & eq;
        is_neq_s = legal_s & ~eq;
    end

    // Lock FSM next-state and run-counter logic. Only legal samples are
    // considered. The run counter restarts whenever the state changes.
    always_comb begin
        state_nxt_s = state_r;
        run_nxt_s   = run_r;
        run_inc_s   = run_r + 4'd1;
        if (legal_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (is_eq_s) begin
                        if (LOCK_ONE) begin
                            state_nxt_s = ST_LOCKED;
                            run_nxt_s   = 4'd0;
                        end else begin
                            state_nxt_s = ST_ACQUIRE;
                            run_nxt_s   = 4'd1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                        run_nxt_s   = 4'd0;
                    end
                end
                ST_ACQUIRE: begin
                    if (is_eq_s) begin
                        if (run_inc_s == LOCK_RUN) begin
                            state_nxt_s = ST_LOCKED;
                            run_nxt_s   = 4'd0;
                        end else begin
                            state_nxt_s = ST_ACQUIRE;
                            run_nxt_s   = run_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                        run_nxt_s   = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (is_neq_s) begin
                        if (UNLOCK_ONE) begin
                            state_nxt_s = ST_IDLE;
                            run_nxt_s   = 4'd0;
                        end else begin
                            state_nxt_s = ST_LOSING;
                            run_nxt_s   = 4'd1;
                        end
                    end else begin
                        state_nxt_s = ST_LOCKED;
                        run_nxt_s   = 4'd0;
                    end
                end
                ST_LOSING: begin
                    if (is_neq_s) begin
                        if (run_inc_s == UNLOCK_RUN) begin
                            state_nxt_s = ST_IDLE;
                            run_nxt_s   = 4'd0;
                        end else begin
                            state_nxt_s = ST_LOSING;
                            run_nxt_s   = run_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_LOCKED;
                        run_nxt_s   = 4'd0;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    run_nxt_s   = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            run_nxt_s   = run_r;
        end
    end

    // Lock FSM registers. locked is derived from the next state, so it
    // changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r  <= ST_IDLE;
            run_r    <= 4'd0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            run_r    <= run_nxt_s;
            locked_r <= (state_nxt_s == ST_LOCKED) || (state_nxt_s == ST_LOSING);
        end
    end

    // Per-outcome saturating event counters, advanced by legal samples only.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            gr_cnt_r <= {CNT_W{1'b0}};
            le_cnt_r <= {CNT_W{1'b0}};
            eq_cnt_r <= {CNT_W{1'b0}};
        end else if (legal_s) begin
            if (gr) begin
                gr_cnt_r <= sat_inc(gr_cnt_r);
            end else begin
                gr_cnt_r <= gr_cnt_r;
            end
            if (le) begin
                le_cnt_r <= sat_inc(le_cnt_r);
            end else begin
                le_cnt_r <= le_cnt_r;
            end
            if (eq) begin
                eq_cnt_r <= sat_inc(eq_cnt_r);
            end else begin
                eq_cnt_r <= eq_cnt_r;
            end
        end else begin
            gr_cnt_r <= gr_cnt_r;
            le_cnt_r <= le_cnt_r;
            eq_cnt_r <= eq_cnt_r;
        end
    end

    // Sticky error flag: set by a malformed valid sample, cleared only by rst/clr.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            err_r <= 1'b0;
        end else if (illegal_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven directly from registers)
    // ------------------------------------------------------------------
    assign gr_cnt = gr_cnt_r;
    assign le_cnt = le_cnt_r;
    assign eq_cnt = eq_cnt_r;
    assign locked = locked_r;
    assign err    = err_r;
    assign state  = state_r;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed self-checking bench for cmp_result_tracker.
// The main instance uses the default parameters. A second instance with
// CNT_W=3 receives the same stimulus and is used for the saturation checks.

module tb_cmp_result_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       gr;
    logic       le;
    logic       eq;
    logic       clr;

    logic [7:0] gr_cnt;
    logic [7:0] le_cnt;
    logic [7:0] eq_cnt;
    logic       locked;
    logic       err;
    logic [1:0] state;

    logic [2:0] s_gr_cnt;
    logic [2:0] s_le_cnt;
    logic [2:0] s_eq_cnt;
    logic       s_locked;
    logic       s_err;
    logic [1:0] s_state;

    int n_assert = 0;
    int n_fail   = 0;

    cmp_result_tracker #(.CNT_W(8), .LOCK_N(4), .UNLOCK_N(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gr(gr), .le(le), .eq(eq),
        .clr(clr), .gr_cnt(gr_cnt), .le_cnt(le_cnt), .eq_cnt(eq_cnt),
        .locked(locked), .err(err), .state(state)
    );

    cmp_result_tracker #(.CNT_W(3), .LOCK_N(4), .UNLOCK_N(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gr(gr), .le(le), .eq(eq),
        .clr(clr), .gr_cnt(s_gr_cnt), .le_cnt(s_le_cnt), .eq_cnt(s_eq_cnt),
        .locked(s_locked), .err(s_err), .state(s_state)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one clock edge, then sample the outputs 1 ns later.
    task automatic drive(input logic v, input logic g, input logic l,
                         input logic e, input logic c);
        in_valid = v;
        gr       = g;
        le       = l;
        eq       = e;
        clr      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        gr       = 1'b0;
        le       = 1'b0;
        eq       = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        // ---- reset with a valid eq sample present ----
        rst = 1'b1; in_valid = 1'b1; gr = 1'b0; le = 1'b0; eq = 1'b1; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; eq = 1'b0;
        chk("rst_gr_cnt", gr_cnt, 0);
        chk("rst_le_cnt", le_cnt, 0);
        chk("rst_eq_cnt", eq_cnt, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err",    err,    0);
        chk("rst_state",  state,  0);

        // ---- lock acquire, 4 back-to-back eq samples ----
        drive(1, 0, 0, 1, 0); chk("acq1_state", state, 1); chk("acq1_locked", locked, 0);
        drive(1, 0, 0, 1, 0); chk("acq2_state", state, 1); chk("acq2_locked", locked, 0);
        drive(1, 0, 0, 1, 0); chk("acq3_state", state, 1); chk("acq3_locked", locked, 0);
        drive(1, 0, 0, 1, 0); chk("acq4_state", state, 2); chk("acq4_locked", locked, 1);
        chk("acq_eq_cnt", eq_cnt, 4);

        // ---- repeat with an invalid gap (flags raised but not valid) ----
        drive(0, 0, 0, 0, 1); chk("clr1_state", state, 0); chk("clr1_eq_cnt", eq_cnt, 0);
        drive(1, 0, 0, 1, 0); chk("gap1_state", state, 1);
        drive(1, 0, 0, 1, 0); chk("gap2_state", state, 1);
        drive(0, 0, 0, 1, 0); chk("gapx_state", state, 1); chk("gapx_eq_cnt", eq_cnt, 2);
        drive(1, 0, 0, 1, 0); chk("gap3_state", state, 1); chk("gap3_locked", locked, 0);
        drive(1, 0, 0, 1, 0); chk("gap4_state", state, 2); chk("gap4_locked", locked, 1);
        chk("gap_eq_cnt", eq_cnt, 4);

        // ---- LOCKED: le then eq -> LOSING then back to LOCKED ----
        drive(1, 0, 1, 0, 0); chk("lose1_state", state, 3); chk("lose1_locked", locked, 1);
        drive(1, 0, 0, 1, 0); chk("relock_state", state, 2); chk("relock_locked", locked, 1);
        chk("relock_le_cnt", le_cnt, 1);
        chk("relock_eq_cnt", eq_cnt, 5);

        // ---- LOCKED: le then gr -> IDLE ----
        drive(1, 0, 1, 0, 0); chk("unl1_state", state, 3); chk("unl1_locked", locked, 1);
        drive(1, 1, 0, 0, 0); chk("unl2_state", state, 0); chk("unl2_locked", locked, 0);
        chk("unl_gr_cnt", gr_cnt, 1);
        chk("unl_le_cnt", le_cnt, 2);

        // ---- acquire abort: eq, eq, gr ----
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 0); chk("abt1_state", state, 1);
        drive(1, 0, 0, 1, 0); chk("abt2_state", state, 1);
        drive(1, 1, 0, 0, 0); chk("abt3_state", state, 0);
        chk("abt_gr_cnt", gr_cnt, 1);
        chk("abt_eq_cnt", eq_cnt, 2);

        // ---- illegal samples inside ACQUIRE ----
        drive(1, 0, 0, 1, 0); chk("ill0_state", state, 1); chk("ill0_err", err, 0);
        drive(1, 1, 0, 1, 0);
        chk("ill1_err", err, 1); chk("ill1_state", state, 1);
        chk("ill1_gr_cnt", gr_cnt, 1); chk("ill1_eq_cnt", eq_cnt, 3);
        drive(1, 0, 0, 0, 0);
        chk("ill2_err", err, 1); chk("ill2_state", state, 1);
        chk("ill2_eq_cnt", eq_cnt, 3); chk("ill2_le_cnt", le_cnt, 0);
        // The run counter kept its value of 1, so three more eq samples lock.
        drive(1, 0, 0, 1, 0); chk("ill3_state", state, 1);
        drive(1, 0, 0, 1, 0); chk("ill4_state", state, 1);
        drive(1, 0, 0, 1, 0); chk("ill5_state", state, 2);
        chk("ill5_err", err, 1); chk("ill5_eq_cnt", eq_cnt, 6);

        // ---- clr with a valid eq while LOCKED with err set ----
        drive(1, 0, 0, 1, 1);
        chk("clrp_gr_cnt", gr_cnt, 0); chk("clrp_eq_cnt", eq_cnt, 0);
        chk("clrp_state", state, 0);   chk("clrp_locked", locked, 0);
        chk("clrp_err", err, 0);

        // ---- rst while LOSING ----
        repeat (4) drive(1, 0, 0, 1, 0);
        chk("pre_rst_locked", locked, 1);
        drive(1, 0, 1, 0, 0); chk("pre_rst_state", state, 3);
        rst = 1'b1;
        drive(1, 0, 0, 1, 0);
        rst = 1'b0;
        chk("rstl_state", state, 0); chk("rstl_locked", locked, 0);
        chk("rstl_eq_cnt", eq_cnt, 0); chk("rstl_le_cnt", le_cnt, 0);
        chk("rstl_err", err, 0);

        // ---- saturation on the CNT_W=3 instance: 10 gr samples ----
        for (int i = 1; i <= 10; i++) begin
            drive(1, 1, 0, 0, 0);
            chk($sformatf("sat_gr_cnt_%0d", i), s_gr_cnt, (i > 7) ? 7 : i);
        end
        chk("sat_le_cnt", s_le_cnt, 0);
        chk("sat_eq_cnt", s_eq_cnt, 0);
        chk("sat_main_gr_cnt", gr_cnt, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
